// File: rtl/reg_dump_ctrl.sv
// -----------------------------------------------------------------------------
// reg_dump_ctrl
//
// Debug sequencer that reads the pipeline register file out through the
// instruction-override path. For each register it forces one harmless read
// instruction (addi rs=idx, rt=$0, imm=0) into the pipeline and waits for the
// operand to appear on busA_probe. It then captures the value and presents
// {dump_reg, dump_data} on a valid/ready port.
//
// Optional feature macro: REGDUMP_CHECKSUM_EN
//   When defined, a dump_csum output carries the XOR of every captured word.
//   It is cleared when a dump starts and is final from the DONE cycle until the
//   next start. When undefined, neither the port nor the accumulator exists.
//
// Parameters:
//   NUM_REGS     registers dumped, idx 0..NUM_REGS-1 (legal 1..32)
//   CAPTURE_LAT  cycles from a force_inst change until busA_probe carries the
//                matching operand (legal >= 1)
// -----------------------------------------------------------------------------
module reg_dump_ctrl #(
    parameter int NUM_REGS    = 32,
    parameter int CAPTURE_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        override_inst,
    output logic [31:0] force_inst,
    input  logic [31:0] busA_probe,
    output logic        dump_valid,
    input  logic        dump_ready,
    output logic [4:0]  dump_reg,
    output logic [31:0] dump_data
`ifdef REGDUMP_CHECKSUM_EN
    ,
    output logic [31:0] dump_csum
`endif
);

    // Wait counter must hold the value CAPTURE_LAT itself.
    localparam int CNT_W = (CAPTURE_LAT < 1) ? 1 : $clog2(CAPTURE_LAT + 1);

    // Index of the final register; the dump stops here and never wraps.
    localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

    // Primary opcode of addi.
    localparam logic [5:0] OP_ADDI = 6'b001000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_OUT,
        S_DONE
    } state_t;

    state_t             state;
    logic [4:0]         idx;
    logic [CNT_W-1:0]   wait_cnt;

    // Read-only probe instruction: addi rs=reg, rt=$0, imm=0. Writing $0 keeps
    // architectural state untouched while the operand flows down read port A.
    function automatic logic [31:0] read_inst(input logic [4:0] reg_idx);
        return {OP_ADDI, reg_idx, 5'b00000, 16'h0000};
    endfunction

    // Sequencer: every output is a register so the instruction mux select and
    // the forced word never glitch between ISSUE and DONE.
    // NOTE: all state uses non-blocking assignments so every branch below sees
    // the pre-edge values of idx, wait_cnt and the outputs, whatever the order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the async reset clears the outputs too, so override_inst
            // releases the pipeline immediately and a partial dump is dropped.
            state         <= S_IDLE;
            idx           <= '0;
            wait_cnt      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            override_inst <= 1'b0;
            force_inst    <= '0;
            dump_valid    <= 1'b0;
            dump_reg      <= '0;
            dump_data     <= '0;
`ifdef REGDUMP_CHECKSUM_EN
            dump_csum     <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state         <= S_ISSUE;
                        idx           <= '0;
                        busy          <= 1'b1;
                        override_inst <= 1'b1;
                        force_inst    <= read_inst(5'd0);
`ifdef REGDUMP_CHECKSUM_EN
                        dump_csum     <= '0;
`endif
                    end
                end

                S_ISSUE: begin
                    // force_inst already shows the probe for idx; start timing
                    // the pipeline latency from here.
                    wait_cnt <= CNT_W'(CAPTURE_LAT);
                    state    <= S_WAIT;
                end

                S_WAIT: begin
                    if (wait_cnt == CNT_W'(1)) begin
                        dump_data  <= busA_probe;
                        dump_reg   <= idx;
                        dump_valid <= 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
                        dump_csum  <= dump_csum ^ busA_probe;
`endif
                        state      <= S_OUT;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end

                S_OUT: begin
                    // Beat is held untouched until the consumer takes it.
                    if (dump_ready) begin
                        dump_valid <= 1'b0;
                        if (idx == LAST_IDX) begin
                            state         <= S_DONE;
                            done          <= 1'b1;
                            override_inst <= 1'b0;
                            force_inst    <= '0;
                        end else begin
                            idx        <= idx + 5'd1;
                            force_inst <= read_inst(idx + 5'd1);
                            state      <= S_ISSUE;
                        end
                    end
                end

                S_DONE: begin
                    // start is deliberately not looked at here; a held start
                    // is picked up from IDLE one cycle later.
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// -----------------------------------------------------------------------------
// tb_reg_dump_ctrl
//
// Self-checking bench for reg_dump_ctrl. A small pipeline model turns
// force_inst into busA_probe after CAPTURE_LAT cycles (earlier it shows the
// previous operand). Expected beats are derived directly from the register
// array: beat k must be {k, regs[k]}. Define REGDUMP_CHECKSUM_EN to include
// the checksum checks.
// -----------------------------------------------------------------------------
module tb_reg_dump_ctrl;

    localparam int NUM_REGS    = 32;
    localparam int CAPTURE_LAT = 2;
    localparam int BEAT_PERIOD = 2 + CAPTURE_LAT;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        dump_ready = 1'b0;
    logic        busy, done, override_inst, dump_valid;
    logic [31:0] force_inst, busA_probe, dump_data;
    logic [4:0]  dump_reg;
`ifdef REGDUMP_CHECKSUM_EN
    logic [31:0] dump_csum;
`endif

    int n_pass  = 0;
    int n_total = 0;

    // Clock generation.
    always #5 clk = ~clk;

    reg_dump_ctrl #(
        .NUM_REGS    (NUM_REGS),
        .CAPTURE_LAT (CAPTURE_LAT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .override_inst (override_inst),
        .force_inst    (force_inst),
        .busA_probe    (busA_probe),
        .dump_valid    (dump_valid),
        .dump_ready    (dump_ready),
        .dump_reg      (dump_reg),
        .dump_data     (dump_data)
`ifdef REGDUMP_CHECKSUM_EN
        ,
        .dump_csum     (dump_csum)
`endif
    );

    // Pipeline model: operand of force_inst reaches busA_probe two cycles later.
    logic [31:0] regs [NUM_REGS];
    logic [31:0] inst_d1 = '0;
    logic [31:0] inst_d2 = '0;
    always @(posedge clk) begin
        inst_d1 <= force_inst;
        inst_d2 <= inst_d1;
    end
    assign busA_probe = regs[inst_d2[25:21]];

    // Observation log, sampled on the falling edge.
    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
        int          cyc;
    } beat_t;

    beat_t       beats [$];
    logic [31:0] issues [$];
    logic [31:0] last_inst = '0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          ov_gap = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        beat_t b;
        if (!reset) begin
            if (dump_valid && dump_ready) begin
                b.r = dump_reg;
                b.d = dump_data;
                b.cyc = cyc;
                beats.push_back(b);
            end
            if (done) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
            end
            if (override_inst && force_inst != last_inst) issues.push_back(force_inst);
            last_inst = override_inst ? force_inst : 32'h0;
            if (busy && !done && !override_inst) ov_gap = ov_gap + 1;
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic logic [31:0] enc(input int i);
        return {6'b001000, 5'(i), 21'b0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        start = 1'b0;
        dump_ready = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic clear_log();
        beats.delete();
        issues.delete();
        done_cnt = 0;
        ov_gap = 0;
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < NUM_REGS; i++) regs[i] = 32'h1000_0000 + 32'(i);
    endtask

    task automatic start_pulse();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input bit rand_ready, input int budget, input string tag);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            dump_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            step();
            n++;
        end
        check({tag, "_done_seen"}, 32'(done), 32'd1);
        dump_ready = 1'b1;
    endtask

    task automatic check_beats(input string tag);
        int bad = 0;
        check({tag, "_beat_count"}, beats.size(), NUM_REGS);
        foreach (beats[i]) begin
            if (i >= NUM_REGS) bad++;
            else if (beats[i].r != 5'(i) || beats[i].d != regs[i]) bad++;
        end
        check({tag, "_beat_errors"}, bad, 0);
    endtask

    function automatic logic [31:0] xor_regs();
        logic [31:0] x = '0;
        for (int i = 0; i < NUM_REGS; i++) x ^= regs[i];
        return x;
    endfunction

    // Cycle vectors from the start edge: inputs for the cycle, outputs after it.
    typedef struct {
        logic        st;
        logic        rdy;
        logic        busy;
        logic        ovr;
        logic        valid;
        logic [4:0]  rg;
        logic [31:0] inst;
    } vec_t;

    initial begin
        vec_t vec [11];
        int   n;
        int   bad;
        int   seen10;
        logic [31:0] snap_d;
        bit   held;

        vec[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h2000_0000};
        vec[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h2000_0000};
        vec[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h2000_0000};
        vec[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd0, 32'h2000_0000};
        vec[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd0, 32'h2000_0000};
        vec[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd0, 32'h2000_0000};
        vec[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h2020_0000};
        vec[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h2020_0000};
        vec[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h2020_0000};
        vec[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd1, 32'h2020_0000};
        vec[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h2040_0000};

        fill_ramp();

        // Reset values, checked with reset asserted and no clock edge involved.
        #2 reset = 1'b1;
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_override", 32'(override_inst), 0);
        check("rst_force_inst", force_inst, 0);
        check("rst_valid", 32'(dump_valid), 0);
        check("rst_reg", 32'(dump_reg), 0);
        check("rst_data", dump_data, 0);
`ifdef REGDUMP_CHECKSUM_EN
        check("rst_csum", dump_csum, 0);
`endif

        // Vector table: start, first two beats, backpressure, ignored start.
        do_reset();
        clear_log();
        for (int k = 0; k < 11; k++) begin
            start = vec[k].st;
            dump_ready = vec[k].rdy;
            step();
            check($sformatf("vec%0d_busy", k), 32'(busy), 32'(vec[k].busy));
            check($sformatf("vec%0d_override", k), 32'(override_inst), 32'(vec[k].ovr));
            check($sformatf("vec%0d_valid", k), 32'(dump_valid), 32'(vec[k].valid));
            check($sformatf("vec%0d_inst", k), force_inst, vec[k].inst);
            if (vec[k].valid) begin
                check($sformatf("vec%0d_reg", k), 32'(dump_reg), 32'(vec[k].rg));
                check($sformatf("vec%0d_data", k), dump_data, regs[vec[k].rg]);
            end
        end
        start = 1'b0;
        wait_done(1'b0, 400, "tab");
        repeat (3) step();
        check_beats("tab");

        // T1/T2: full dump with ready high, timing and instruction encoding.
        do_reset();
        fill_ramp();
        clear_log();
        start_pulse();
        n = cyc;
        wait_done(1'b0, 400, "t1");
        repeat (3) step();
        check_beats("t1");
        check("t1_first_latency", (beats.size() > 0) ? beats[0].cyc - n : -1, 1 + CAPTURE_LAT);
        bad = 0;
        for (int i = 1; i < beats.size(); i++)
            if (beats[i].cyc - beats[i-1].cyc != BEAT_PERIOD) bad++;
        check("t1_beat_spacing_errors", bad, 0);
        check("t1_done_after_last", (beats.size() > 0) ? done_cyc - beats[beats.size()-1].cyc : -1, 1);
        check("t1_done_pulses", done_cnt, 1);
        check("t1_busy_after", 32'(busy), 0);
        check("t2_issue_count", issues.size(), NUM_REGS);
        check("t2_inst_idx5", (issues.size() > 5) ? issues[5] : 32'hDEAD_BEEF, 32'h20A0_0000);
        check("t2_inst_idx31", (issues.size() > 31) ? issues[31] : 32'hDEAD_BEEF, 32'h23E0_0000);
        bad = 0;
        foreach (issues[i]) if (issues[i] != enc(i)) bad++;
        check("t2_inst_errors", bad, 0);
        check("t2_override_gaps", ov_gap, 0);

        // T3: random data, 10-cycle stall on reg 3, random backpressure elsewhere.
        do_reset();
        for (int i = 0; i < NUM_REGS; i++) regs[i] = $urandom;
        clear_log();
        start_pulse();
        n = 0;
        held = 1'b0;
        bad = 0;
        snap_d = '0;
        while (done !== 1'b1 && n < 2000) begin
            if (!held && dump_valid && dump_reg == 5'd3) begin
                held = 1'b1;
                snap_d = dump_data;
                dump_ready = 1'b0;
                repeat (10) begin
                    step();
                    if (dump_valid !== 1'b1 || dump_reg !== 5'd3 || dump_data !== snap_d
                        || force_inst !== enc(3)) bad++;
                end
            end
            dump_ready = ($urandom_range(0, 2) != 0);
            step();
            n++;
        end
        check("t3_done_seen", 32'(done), 1);
        check("t3_stall_seen", 32'(held), 1);
        check("t3_stall_data", snap_d, regs[3]);
        check("t3_stall_errors", bad, 0);
`ifdef REGDUMP_CHECKSUM_EN
        check("t3_csum", dump_csum, xor_regs());
`endif
        repeat (3) step();
        check_beats("t3");
        check("t3_override_gaps", ov_gap, 0);

        // T4: reset while reg 7 waits in OUT, then a fresh dump starts at reg 0.
        do_reset();
        fill_ramp();
        clear_log();
        start_pulse();
        dump_ready = 1'b1;
        n = 0;
        while (!(dump_valid && dump_reg == 5'd7) && n < 400) begin
            step();
            n++;
        end
        check("t4_reached_reg7", 32'(dump_valid && dump_reg == 5'd7), 1);
        dump_ready = 1'b0;
        #3 reset = 1'b1;
        #1;
        check("t4_async_override", 32'(override_inst), 0);
        check("t4_async_busy", 32'(busy), 0);
        check("t4_async_valid", 32'(dump_valid), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        clear_log();
        dump_ready = 1'b1;
        start_pulse();
        n = 0;
        while (dump_valid !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        check("t4_restart_valid", 32'(dump_valid), 1);
        check("t4_restart_reg", 32'(dump_reg), 0);
        check("t4_restart_data", dump_data, regs[0]);

        // T5: start pulses during WAIT of reg 10 and during DONE are ignored.
        do_reset();
        fill_ramp();
        clear_log();
        start_pulse();
        n = 0;
        seen10 = 0;
        while (done !== 1'b1 && n < 400) begin
            start = 1'b0;
            if (override_inst && force_inst == enc(10)) seen10++;
            if (seen10 == 2) start = 1'b1;
            dump_ready = 1'b1;
            step();
            n++;
        end
        check("t5_done_seen", 32'(done), 1);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        check("t5_busy_after", 32'(busy), 0);
        check("t5_done_pulses", done_cnt, 1);
        check_beats("t5");

        // Held start: DONE ignores it, IDLE retriggers one cycle later.
        do_reset();
        fill_ramp();
        start = 1'b1;
        dump_ready = 1'b1;
        wait_done(1'b0, 400, "held");
        step();
        check("held_idle_busy", 32'(busy), 0);
        check("held_idle_done", 32'(done), 0);
        step();
        check("held_retrig_busy", 32'(busy), 1);
        check("held_retrig_inst", force_inst, enc(0));
        start = 1'b0;

`ifdef REGDUMP_CHECKSUM_EN
        // T6: one-hot registers fold to all ones; zero registers to zero.
        do_reset();
        for (int i = 0; i < NUM_REGS; i++) regs[i] = 32'h1 << i;
        start_pulse();
        wait_done(1'b0, 400, "t6a");
        check("t6_csum_ones", dump_csum, 32'hFFFF_FFFF);
        step();
        check("t6_csum_hold_idle", dump_csum, 32'hFFFF_FFFF);
        for (int i = 0; i < NUM_REGS; i++) regs[i] = '0;
        start_pulse();
        check("t6_csum_cleared", dump_csum, 0);
        wait_done(1'b0, 400, "t6b");
        check("t6_csum_zero", dump_csum, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
